// File: rtl/dwc_gearbox.sv
// dwc_gearbox: LSB-first stream width converter for arbitrary IBITS->OBITS ratios.
// Outputs decode only from cnt_q/buf_q, so no input reaches an output combinationally.
module dwc_gearbox #(
  parameter int IBITS = 24,
  parameter int OBITS = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             irdy,
  input  logic             ivld,
  input  logic [IBITS-1:0] idat,
  input  logic             ordy,
  output logic             ovld,
  output logic [OBITS-1:0] odat
);
  localparam int CAP = OBITS + 2*IBITS - 1;
  localparam int CW = $clog2(CAP + 1);
  localparam logic [CW-1:0] OB = CW'(OBITS);
  localparam logic [CW-1:0] IB = CW'(IBITS);
  localparam logic [CW-1:0] ILIM = CW'(CAP - IBITS);
  localparam logic [CAP-1:0] IMASK = CAP'({IBITS{1'b1}});
  logic [CAP-1:0] buf_q, buf_d, shifted;
  logic [CW-1:0] cnt_q, cnt_d, c1;
  logic ifire, ofire;
  assign ovld = cnt_q >= OB;
  assign irdy = cnt_q <= ILIM;
  assign odat = buf_q[OBITS-1:0];
  assign ifire = ivld && irdy;
  assign ofire = ovld && ordy;
  // new input lands directly above whatever survives the output shift
  always_comb begin
    c1 = ofire ? cnt_q - OB : cnt_q;
    shifted = ofire ? buf_q >> OBITS : buf_q;
    buf_d = ifire ? (shifted & ~(IMASK << c1)) | (CAP'(idat) << c1) : shifted;
    cnt_d = ifire ? c1 + IB : c1;
  end
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    cnt_q <= rst_n ? cnt_d : '0;
  end
endmodule

// File: tb/tb_dwc_gearbox.sv
// tb_dwc_gearbox: random and directed stimulus on 24->32 and 40->24 gearboxes,
// checked every cycle against a bit-stream model (bits in minus bits out).
module tb_dwc_gearbox;
  logic clk = 0;
  logic rst_n = 0;
  logic ivld [2];
  logic ordy [2];
  logic [63:0] idat [2];
  logic [1:0] ovld_w, irdy_w;
  logic [31:0] od0;
  logic [23:0] od1;
  int n_tests = 0, n_fail = 0;
  int wr [2], rd [2], ifc [2], ofc [2], lowc [2];
  bit sbits [2][65536];
  bit armed = 0;
  logic [63:0] got0 [$];

  always #5 clk = ~clk;

  dwc_gearbox #(.IBITS(24), .OBITS(32)) u0 (
    .clk(clk), .rst_n(rst_n), .irdy(irdy_w[0]), .ivld(ivld[0]), .idat(idat[0][23:0]),
    .ordy(ordy[0]), .ovld(ovld_w[0]), .odat(od0)
  );
  dwc_gearbox #(.IBITS(40), .OBITS(24)) u1 (
    .clk(clk), .rst_n(rst_n), .irdy(irdy_w[1]), .ivld(ivld[1]), .idat(idat[1][39:0]),
    .ordy(ordy[1]), .ovld(ovld_w[1]), .odat(od1)
  );

  function automatic int ib(int k); return (k != 0) ? 40 : 24; endfunction
  function automatic int ob(int k); return (k != 0) ? 24 : 32; endfunction

  task automatic check(input string n, input logic [63:0] a, input logic [63:0] e);
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", n, a, e);
    end
  endtask

  // model: pending bits are stream[rd..wr); fill thresholds give ovld/irdy
  task automatic checker_loop();
    int fill, cap;
    logic [63:0] a, e, ix;
    logic ev, er;
    forever begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        fill = wr[k] - rd[k];
        cap = ob(k) + 2*ib(k) - 1;
        ev = fill >= ob(k);
        er = fill <= cap - ib(k);
        a = (k != 0) ? 64'(od1) : 64'(od0);
        e = '0;
        for (int j = 0; j < ob(k); j++) e[j] = sbits[k][(rd[k] + j) & 16'hFFFF];
        if (armed) begin
          check($sformatf("u%0d_ovld", k), 64'(ovld_w[k]), 64'(ev));
          check($sformatf("u%0d_irdy", k), 64'(irdy_w[k]), 64'(er));
          if (ev) check($sformatf("u%0d_odat", k), a, e);
        end
        if (!rst_n) rd[k] = wr[k];
        else if (armed) begin
          if (!irdy_w[k]) lowc[k]++;
          if (ordy[k] && ev) begin
            rd[k] += ob(k);
            ofc[k]++;
            if (k == 0) got0.push_back(a);
          end
          if (ivld[k] && er) begin
            ix = idat[k];
            for (int j = 0; j < ib(k); j++) sbits[k][(wr[k] + j) & 16'hFFFF] = ix[j];
            wr[k] += ib(k);
            ifc[k]++;
          end
        end
      end
      if (!rst_n) armed = 1;
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 0;
    for (int k = 0; k < 2; k++) begin
      ivld[k] = 0;
      ordy[k] = 0;
      idat[k] = '0;
    end
    tick(2);
    rst_n = 1;
  endtask

  initial begin
    int base, bi, bo, bl, drop, nin, nout, waited;
    logic [31:0] hold;
    logic [31:0] w1 [3];
    w1 = '{32'h02000001, 32'h00030000, 32'h00000400};
    for (int k = 0; k < 2; k++) begin
      wr[k] = 0; rd[k] = 0; ifc[k] = 0; ofc[k] = 0; lowc[k] = 0;
    end
    fork checker_loop(); join_none
    do_reset();
    check("rst_ovld", 64'(ovld_w[0]), 64'd0);
    check("rst_irdy", 64'(irdy_w[0]), 64'd1);

    // 24->32 directed packing
    ordy[0] = 1;
    base = got0.size();
    for (int i = 0; i < 4; i++) begin
      ivld[0] = 1;
      idat[0] = 64'(i + 1);
      tick(1);
    end
    ivld[0] = 0;
    tick(4);
    check("t1_nwords", 64'(got0.size() - base), 64'd3);
    for (int i = 0; i < 3; i++)
      if (base + i < got0.size()) check($sformatf("t1_word%0d", i), got0[base + i], 64'(w1[i]));

    // 24->32 full rate
    do_reset();
    ordy[0] = 1;
    ivld[0] = 1;
    bi = ifc[0]; bo = ofc[0]; bl = lowc[0];
    for (int i = 0; i < 400; i++) begin
      idat[0] = {$urandom, $urandom};
      tick(1);
    end
    ivld[0] = 0;
    tick(5);
    check("t2_irdy_low", 64'(lowc[0] - bl), 64'd0);
    check("t2_ifire", 64'(ifc[0] - bi), 64'd400);
    check("t2_ofire", 64'(ofc[0] - bo), 64'd300);
    check("t2_idle_ovld", 64'(ovld_w[0]), 64'd0);

    // 40->24 full rate
    do_reset();
    ordy[1] = 1;
    ivld[1] = 1;
    bi = ifc[1]; bo = ofc[1];
    waited = 0;
    while (!ovld_w[1] && waited < 8) begin
      idat[1] = {$urandom, $urandom};
      tick(1);
      waited++;
    end
    check("t3_first_word", 64'(ovld_w[1]), 64'd1);
    drop = 0;
    for (int i = 0; i < 300; i++) begin
      idat[1] = {$urandom, $urandom};
      tick(1);
      if (!ovld_w[1]) drop++;
    end
    ivld[1] = 0;
    tick(8);
    check("t3_ovld_drops", 64'(drop), 64'd0);
    nin = (ifc[1] - bi) * 40;
    nout = (ofc[1] - bo) * 24;
    check("t3_bits_kept", 64'(nin >= nout && nin - nout < 24), 64'd1);
    check("t3_ratio", 64'((ofc[1] - bo) * 3 >= (ifc[1] - bi) * 5 - 3), 64'd1);

    // 24->32 backpressure from reset
    do_reset();
    ivld[0] = 1;
    bi = ifc[0];
    for (int i = 0; i < 6; i++) begin
      idat[0] = {$urandom, $urandom};
      tick(1);
    end
    check("t4_accepted", 64'(ifc[0] - bi), 64'd3);
    check("t4_irdy", 64'(irdy_w[0]), 64'd0);
    check("t4_ovld", 64'(ovld_w[0]), 64'd1);
    hold = od0;
    tick(2);
    check("t4_hold", 64'(od0), 64'(hold));
    ordy[0] = 1;
    bo = ofc[0];
    tick(3);
    check("t4_drain", 64'(ofc[0] - bo), 64'd3);

    // reset mid-stream with 40 bits buffered
    do_reset();
    ivld[0] = 1;
    idat[0] = 64'hFFFFFF;
    tick(3);
    ivld[0] = 0;
    ordy[0] = 1;
    tick(1);
    ordy[0] = 0;
    check("t6_pre_ovld", 64'(ovld_w[0]), 64'd1);
    check("t6_pre_irdy", 64'(irdy_w[0]), 64'd1);
    rst_n = 0;
    tick(1);
    rst_n = 1;
    check("t6_post_ovld", 64'(ovld_w[0]), 64'd0);
    check("t6_post_irdy", 64'(irdy_w[0]), 64'd1);
    base = got0.size();
    ordy[0] = 1;
    ivld[0] = 1;
    idat[0] = 64'hAAAAAA;
    tick(1);
    idat[0] = 64'h555555;
    tick(1);
    ivld[0] = 0;
    tick(3);
    check("t6_nwords", 64'(got0.size() - base), 64'd1);
    if (got0.size() > base) check("t6_word", got0[base], 64'h55AAAAAA);

    // random handshakes on both ratios
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      for (int k = 0; k < 2; k++) begin
        ivld[k] = 1'($urandom_range(0, 1));
        ordy[k] = 1'($urandom_range(0, 1));
        idat[k] = {$urandom, $urandom};
      end
      tick(1);
    end
    for (int k = 0; k < 2; k++) begin
      ivld[k] = 0;
      ordy[k] = 1;
    end
    tick(10);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
